// File: rtl/dcache_mem_bridge.sv
// Byte-serial RAM responder for data-cache block fills, dirty write-backs and uncached IO accesses.
// One shared read pipeline: an address issued in one cycle is captured from ramDataIn the next.
module dcache_mem_bridge #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      readyIn,
  input  logic                      clearIn,
  input  logic                      missIn,
  input  logic [31:BLOCK_WIDTH]     missAddrIn,
  input  logic                      readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0]   writeBackIn,
  input  logic                      ioValidIn,
  input  logic [1:0]                ioAccessType,
  input  logic                      ioReadWriteIn,
  input  logic [31:0]               ioAddrIn,
  input  logic [31:0]               ioDataIn,
  input  logic                      ioBufferFull,
  input  logic [7:0]                ramDataIn,
  output logic [31:0]               ramAddrOut,
  output logic                      ramWriteOut,
  output logic [7:0]                ramDataOut,
  output logic                      memDataValid,
  output logic [31:BLOCK_WIDTH]     memAddr,
  output logic [BLOCK_SIZE*8-1:0]   memDataOut,
  output logic                      acceptWrite,
  output logic                      mutableMemInValid,
  output logic [31:0]               mutableMemDataOut,
  output logic                      mutableWriteSuc
);

  localparam int IW = BLOCK_WIDTH + 1;
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [2:0] {IDLE, FILL, WBACK, IO_RD, IO_WR, DONE} state_t;

  state_t                  state, state_nx, done_kind;
  logic [IW-1:0]           idx, idx_p1, len;
  logic                    vld_p1, io_clr;
  logic [31:BLOCK_WIDTH]   blk_addr, mem_addr_q;
  logic [31:0]             io_addr, io_wdata, io_rdata, ram_addr_q, cur_addr;
  logic [BLOCK_SIZE*8-1:0] wb_data, fill_data;
  logic                    accept_miss, accept_io, issue, wr_cycle, capture, lost;

  function automatic logic [IW-1:0] io_len(input logic [1:0] t);
    case (t)
      2'b01:   io_len = IW'(1);
      2'b10:   io_len = IW'(2);
      2'b11:   io_len = IW'(4);
      default: io_len = '0;
    endcase
  endfunction

  always_ff @(posedge clkIn) begin
    if (resetIn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    accept_miss       = 1'b0;
    accept_io         = 1'b0;
    issue             = 1'b0;
    wr_cycle          = 1'b0;
    cur_addr          = ram_addr_q;
    ramDataOut        = '0;
    memDataValid      = 1'b0;
    acceptWrite       = 1'b0;
    mutableMemInValid = 1'b0;
    mutableWriteSuc   = 1'b0;
    capture           = vld_p1 && readyIn;
    lost              = vld_p1 && !readyIn;
    case (state)
      IDLE: begin
        if (readyIn) begin
          if (missIn) begin
            accept_miss = 1'b1;
            state_nx    = readWriteIn ? FILL : WBACK;
          end else if (ioValidIn && ioAccessType != 2'b00 && !(ioReadWriteIn && clearIn)) begin
            accept_io = 1'b1;
            state_nx  = ioReadWriteIn ? IO_RD : IO_WR;
          end
        end
      end
      FILL, IO_RD: begin
        // Issue phase while idx<len; the final cycle only waits for the last capture.
        if (idx < len) begin
          cur_addr = (state == FILL) ? {blk_addr, idx[BLOCK_WIDTH-1:0]} : io_addr + 32'(idx);
          issue    = readyIn;
        end else if (readyIn) begin
          state_nx = DONE;
        end
      end
      WBACK, IO_WR: begin
        cur_addr = (state == WBACK) ? {blk_addr, idx[BLOCK_WIDTH-1:0]} : io_addr + 32'(idx);
        wr_cycle = readyIn && (state == WBACK || !ioBufferFull);
        if (wr_cycle) begin
          ramDataOut = (state == WBACK) ? wb_data[{idx[BLOCK_WIDTH-1:0], 3'b000} +: 8]
                                        : io_wdata[{idx[1:0], 3'b000} +: 8];
          if (idx == len - ONE) state_nx = DONE;
        end
      end
      DONE: begin
        if (readyIn) begin
          state_nx = IDLE;
          case (done_kind)
            FILL:    memDataValid      = 1'b1;
            WBACK:   acceptWrite       = 1'b1;
            IO_RD:   mutableMemInValid = !io_clr && !clearIn;
            IO_WR:   mutableWriteSuc   = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ramWriteOut       = wr_cycle;
  assign ramAddrOut        = cur_addr;
  assign memAddr           = mem_addr_q;
  assign memDataOut        = fill_data;
  assign mutableMemDataOut = io_rdata;

  // Issue stage (p0) -> capture stage (p1)
  always_ff @(posedge clkIn) begin
    idx_p1 <= idx;
    if (accept_miss) begin
      blk_addr <= missAddrIn;
      wb_data  <= writeBackIn;
      len      <= IW'(BLOCK_SIZE);
    end
    if (accept_io) begin
      io_addr  <= ioAddrIn;
      io_wdata <= ioDataIn;
      len      <= io_len(ioAccessType);
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      idx        <= '0;
      vld_p1     <= 1'b0;
      io_clr     <= 1'b0;
      done_kind  <= IDLE;
      ram_addr_q <= '0;
      mem_addr_q <= '0;
      fill_data  <= '0;
      io_rdata   <= '0;
    end else begin
      ram_addr_q <= cur_addr;
      vld_p1     <= issue;
      if (accept_miss || accept_io) begin
        idx       <= '0;
        done_kind <= state_nx;
      end else if (issue || wr_cycle) begin
        idx <= idx + ONE;
      end else if (lost) begin
        // Capture missed by a stall: rewind so the same address is re-issued on resume.
        idx <= idx_p1;
      end
      if (accept_miss) mem_addr_q <= missAddrIn;
      if (accept_io) begin
        io_rdata <= '0;
        io_clr   <= 1'b0;
      end
      if (state == IO_RD && clearIn) io_clr <= 1'b1;
      if (capture) begin
        if (state == FILL) fill_data[{idx_p1[BLOCK_WIDTH-1:0], 3'b000} +: 8] <= ramDataIn;
        else               io_rdata[{idx_p1[1:0], 3'b000} +: 8]              <= ramDataIn;
      end
    end
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: fills, write-backs, IO reads/writes, clear, stall and reset.
module tb_dcache_mem_bridge;

  logic          clkIn = 1'b0;
  logic          resetIn, readyIn, clearIn, missIn, readWriteIn;
  logic [31:4]   missAddrIn;
  logic [127:0]  writeBackIn;
  logic          ioValidIn, ioReadWriteIn, ioBufferFull;
  logic [1:0]    ioAccessType;
  logic [31:0]   ioAddrIn, ioDataIn;
  logic [7:0]    ramDataIn;
  logic [31:0]   ramAddrOut;
  logic          ramWriteOut;
  logic [7:0]    ramDataOut;
  logic          memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc;
  logic [31:4]   memAddr;
  logic [127:0]  memDataOut;
  logic [31:0]   mutableMemDataOut;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  logic [31:0] addr_log [0:1023];
  logic [31:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  int n_mdv = 0, n_aw = 0, n_miv = 0, n_mws = 0;
  int t_mdv, t_aw, t_miv, t_mws;
  logic [127:0] d_mdv;
  logic [31:4]  a_mdv, a_aw;
  logic [31:0]  d_miv;

  dcache_mem_bridge dut (
    .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .missIn(missIn), .missAddrIn(missAddrIn), .readWriteIn(readWriteIn),
    .writeBackIn(writeBackIn), .ioValidIn(ioValidIn), .ioAccessType(ioAccessType),
    .ioReadWriteIn(ioReadWriteIn), .ioAddrIn(ioAddrIn), .ioDataIn(ioDataIn),
    .ioBufferFull(ioBufferFull), .ramDataIn(ramDataIn), .ramAddrOut(ramAddrOut),
    .ramWriteOut(ramWriteOut), .ramDataOut(ramDataOut), .memDataValid(memDataValid),
    .memAddr(memAddr), .memDataOut(memDataOut), .acceptWrite(acceptWrite),
    .mutableMemInValid(mutableMemInValid), .mutableMemDataOut(mutableMemDataOut),
    .mutableWriteSuc(mutableWriteSuc)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (a == 32'h30004) return 8'hAB;
    if (a == 32'h30005) return 8'hCD;
    return a[7:0];
  endfunction

  function automatic logic [127:0] blk_exp(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  // RAM answers one cycle after the address; monitor logs writes and completion pulses.
  always @(posedge clkIn) begin
    ramDataIn <= ram_byte(ramAddrOut);
    addr_log[cyc % 1024] <= ramAddrOut;
    if (ramWriteOut) begin
      wq_addr.push_back(ramAddrOut);
      wq_data.push_back(ramDataOut);
      wq_cyc.push_back(cyc);
    end
    if (memDataValid)      begin n_mdv <= n_mdv + 1; t_mdv <= cyc; d_mdv <= memDataOut; a_mdv <= memAddr; end
    if (acceptWrite)       begin n_aw  <= n_aw + 1;  t_aw  <= cyc; a_aw  <= memAddr; end
    if (mutableMemInValid) begin n_miv <= n_miv + 1; t_miv <= cyc; d_miv <= mutableMemDataOut; end
    if (mutableWriteSuc)   begin n_mws <= n_mws + 1; t_mws <= cyc; end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  function automatic logic [31:0] alog(input int c);
    return addr_log[c % 1024];
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ramaddr"}, ramAddrOut, 0);
    chk({tag, "_ramwr"}, ramWriteOut, 0);
    chk({tag, "_ramdata"}, ramDataOut, 0);
    chk({tag, "_memaddr"}, memAddr, 0);
    chk({tag, "_memdata"}, memDataOut, 0);
    chk({tag, "_iodata"}, mutableMemDataOut, 0);
    chk({tag, "_pulses"}, {memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc}, 0);
  endtask

  task automatic run_fill(input string tag, input logic [27:0] blk, input int stall_from,
                          input int stall_to, input int exp_lat);
    int T, m0;
    m0 = n_mdv;
    missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = blk;
    T = cyc;
    for (int i = 0; i < 30; i++) begin
      step();
      missIn  = 1'b0;
      readyIn = !(cyc >= T + stall_from && cyc <= T + stall_to);
    end
    readyIn = 1'b1;
    chk({tag, "_pulses"}, n_mdv - m0, 1);
    chk({tag, "_data"}, d_mdv, blk_exp({blk[3:0], 4'h0}));
    chk({tag, "_memaddr"}, a_mdv, blk);
    if (exp_lat > 0) chk({tag, "_time"}, t_mdv - T, exp_lat);
  endtask

  initial begin
    int T, m0;
    logic [31:0] ea [4];
    logic [7:0]  ed [4];
    int          ec [4];

    resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0; missIn = 1'b0; readWriteIn = 1'b0;
    missAddrIn = '0; writeBackIn = '0; ioValidIn = 1'b0; ioAccessType = 2'b00;
    ioReadWriteIn = 1'b0; ioAddrIn = '0; ioDataIn = '0; ioBufferFull = 1'b0;
    repeat (3) step();
    @(negedge clkIn);
    chk_outputs_zero("reset");
    step();
    resetIn = 1'b0;
    step();

    // Block fill of 0x0000123
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    missIn = 1'b1; readWriteIn = 1'b1; missAddrIn = 28'h0000123;
    T = cyc; m0 = n_mdv;
    step(); missIn = 1'b0;
    repeat (22) step();
    for (int k = 0; k < 16; k++) chk("fill_addr", alog(T + 1 + k), 32'h1230 + k);
    chk("fill_pulses", n_mdv - m0, 1);
    chk("fill_time", t_mdv - T, 18);
    chk("fill_data", d_mdv, 128'h3F3E3D3C3B3A39383736353433323130);
    chk("fill_memaddr", a_mdv, 28'h0000123);
    chk("fill_nowrites", wq_addr.size(), 0);

    // Write-back of 0x0000123
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    missIn = 1'b1; readWriteIn = 1'b0; writeBackIn = 128'h0F0E0D0C0B0A09080706050403020100;
    T = cyc; m0 = n_aw;
    step(); missIn = 1'b0;
    int_wait: repeat (22) step();
    chk("wb_count", wq_addr.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < wq_addr.size()) begin
        chk("wb_addr", wq_addr[k], 32'h1230 + k);
        chk("wb_data", wq_data[k], k);
        chk("wb_cycle", wq_cyc[k] - T, 1 + k);
      end
    end
    chk("wb_pulses", n_aw - m0, 1);
    chk("wb_time", t_aw - T, 17);
    chk("wb_memaddr", a_aw, 28'h0000123);
    chk("wb_no_fill", n_mdv - 1, 0);

    // IO word write with the write buffer full for cycles 2-4
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    ioValidIn = 1'b1; ioAccessType = 2'b11; ioReadWriteIn = 1'b0;
    ioAddrIn = 32'h30000; ioDataIn = 32'h44332211;
    T = cyc; m0 = n_mws;
    for (int i = 0; i < 14; i++) begin
      step();
      ioValidIn    = 1'b0;
      ioBufferFull = (cyc >= T + 2 && cyc <= T + 4);
    end
    ioBufferFull = 1'b0;
    ea = '{32'h30000, 32'h30001, 32'h30002, 32'h30003};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    ec = '{1, 5, 6, 7};
    chk("iow_count", wq_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wq_addr.size()) begin
        chk("iow_addr", wq_addr[k], ea[k]);
        chk("iow_data", wq_data[k], ed[k]);
        chk("iow_cycle", wq_cyc[k] - T, ec[k]);
      end
    end
    chk("iow_pulses", n_mws - m0, 1);
    chk("iow_time", t_mws - T, 8);

    // IO half-word read at 0x30004
    ioValidIn = 1'b1; ioAccessType = 2'b10; ioReadWriteIn = 1'b1; ioAddrIn = 32'h30004;
    T = cyc; m0 = n_miv;
    step(); ioValidIn = 1'b0;
    repeat (7) step();
    chk("ior_addr0", alog(T + 1), 32'h30004);
    chk("ior_addr1", alog(T + 2), 32'h30005);
    chk("ior_pulses", n_miv - m0, 1);
    chk("ior_time", t_miv - T, 4);
    chk("ior_data", d_miv, 32'h0000CDAB);

    // Same read with a wrong-branch clear in cycle 2: reads finish, no pulse
    ioValidIn = 1'b1;
    T = cyc; m0 = n_miv;
    for (int i = 0; i < 8; i++) begin
      step();
      ioValidIn = 1'b0;
      clearIn   = (cyc == T + 2);
    end
    clearIn = 1'b0;
    chk("iorclr_addr1", alog(T + 2), 32'h30005);
    chk("iorclr_pulses", n_miv - m0, 0);

    // Clear in IDLE blocks an IO read; access type 00 is ignored
    ioValidIn = 1'b1; clearIn = 1'b1; ioAddrIn = 32'h30100;
    T = cyc; m0 = n_miv;
    step(); ioValidIn = 1'b0; clearIn = 1'b0;
    repeat (5) step();
    chk("idleclr_addr", alog(T + 2), 32'h30005);
    chk("idleclr_pulses", n_miv - m0, 0);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    ioValidIn = 1'b1; ioAccessType = 2'b00; ioReadWriteIn = 1'b0; ioAddrIn = 32'h30200;
    m0 = n_mws; T = cyc;
    step(); ioValidIn = 1'b0;
    repeat (6) step();
    chk("type00_writes", wq_addr.size(), 0);
    chk("type00_pulses", n_mws - m0, 0);
    chk("type00_addr", alog(T + 2), 32'h30005);

    // Stall before the first issue costs exactly the stall length
    run_fill("stall_start", 28'h0000456, 1, 3, 21);
    chk("stall_start_first", alog(t_mdv - 17), 32'h4560);
    // Stall in the middle of a fill: a missed capture is re-read
    run_fill("stall_mid", 28'h0000567, 6, 8, 0);

    // Reset during a write-back
    m0 = n_aw;
    missIn = 1'b1; readWriteIn = 1'b0; missAddrIn = 28'h0000ABC;
    T = cyc;
    for (int i = 0; i < 25; i++) begin
      step();
      missIn  = 1'b0;
      resetIn = (cyc == T + 5);
      if (cyc == T + 6) begin
        @(negedge clkIn);
        chk_outputs_zero("midreset");
      end
    end
    chk("midreset_no_accept", n_aw - m0, 0);
    run_fill("after_reset", 28'h0000789, 0, -1, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
